control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle main control unit for the 32-bit RISC core. Sequences each instruction through fetch, decode, execute, memory and writeback. Produces the datapath strobes plus the `alu_op`/`op_code` pair consumed by the downstream ALU-control decoder. It is the issuing end of that interface: `alu_op` 2'b10 requests add, 2'b01 requests subtract, and 2'b00 defers to `op_code`.

## Interface
Parameters:
- `OPW`, 4, opcode width (instruction bits [15:12])

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `instr_op`  in  OPW  opcode field of the memory read data, sampled when `ir_write`=1
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `zero`  in  1  ALU zero flag, valid in EXEC
- `alu_op`  out  2  ALU class to the ALU-control decoder
- `op_code`  out  OPW  latched opcode to the ALU-control decoder
- `ir_write`, `pc_write`  out  1  IR load; PC load
- `pc_src`  out  2  00 = PC+2, 01 = branch target, 10 = jump target
- `mem_read`, `mem_write`  out  1  memory strobes, held until `mem_ready`
- `i_or_d`  out  1  0 = instruction address, 1 = data address
- `alu_src`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1  datapath muxes and register-file write
- `illegal`  out  1  sticky illegal-opcode flag

## Operation
- Opcode map:
  - 0000 LD; 0001 ST
  - 0010–1001 R-type ALU ops
  - 1011 BEQ; 1100 BNE; 1101 JMP
  - 1010, 1110, 1111 illegal
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP; state register is one-hot or binary (implementer's choice).
- FETCH:
  - `mem_read`=1, `i_or_d`=0.
  - Stays while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, latch `instr_op` into `op_code`, go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC, by opcode:
  - LD/ST: `alu_op`=10, `alu_src`=1, go to MEM.
  - R-type: `alu_op`=00, `alu_src`=0, go to WB.
  - BEQ/BNE: `alu_op`=01. `pc_write`=1 with `pc_src`=01 iff (BEQ and `zero`) or (BNE and !`zero`). Go to FETCH.
  - JMP: `pc_write`=1, `pc_src`=10, `alu_op`=00. Go to FETCH.
  - Illegal: see Configuration.
- MEM:
  - `i_or_d`=1; `mem_read`=1 for LD, `mem_write`=1 for ST.
  - Stays while `mem_ready`=0.
  - On `mem_ready`=1: LD goes to WB, ST goes to FETCH.
- WB: `reg_write`=1 for one cycle. LD: `mem_to_reg`=1, `reg_dst`=0. R-type: `mem_to_reg`=0, `reg_dst`=1. Go to FETCH.
- `alu_op` is 00 in every state except EXEC as specified above.
- `op_code` holds its value from IR load until the next IR load.

## Timing
- All outputs are Moore outputs decoded from the state and the latched `op_code`, except two Mealy terms:
  - the FETCH/MEM strobes gated by `mem_ready`;
  - the EXEC branch `pc_write` gated by `zero`.
- Reset:
  - state = FETCH, `op_code` = 0000, `illegal` = 0.
  - While `reset_n`=0, all strobes are 0; `mem_read` rises in the first cycle after release.
- Cycles per instruction with zero-wait memory: LD 5, ST 4, R-type 4, BEQ/BNE/JMP 3.
- Each wait cycle of `mem_ready`=0 adds one cycle in FETCH or MEM.
- `mem_read` and `mem_write` never assert together; `pc_write` and `reg_write` never assert together.
- Reset mid-instruction: abort immediately with no partial writes; restart at FETCH.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - an illegal opcode in EXEC goes to TRAP and sets `illegal`=1;
  - TRAP holds with all strobes 0 until `reset_n`.
- Not defined:
  - an illegal opcode executes as a NOP (EXEC → FETCH, no strobes);
  - `illegal` is tied 0 and the TRAP state is absent.

## Structure
- Shared package `risc_pkg` holds:
  - opcode constants (OP_LD … OP_JMP);
  - `alu_op` encodings (ALUOP_ADD = 10, ALUOP_SUB = 01, ALUOP_FUNC = 00);
  - `pc_src` encodings;
  - the state enum.
- One sub-module, `ctrl_out_decode`: combinational state/opcode → strobe decoder. `control_fsm` keeps the state and opcode registers.

## Test plan
- Reset then release, memory always ready, `instr_op`=0010 → FETCH, DECODE, EXEC (`alu_op`=00, `op_code`=0010), WB (`reg_write`=1). Back in FETCH on cycle 5.
- LD (0000) with `mem_ready` low for 2 cycles in MEM → `alu_op`=10 in EXEC; `mem_read`=1, `i_or_d`=1 for 3 cycles; then WB with `mem_to_reg`=1. 7 cycles total.
- BEQ (1011), `zero`=1 → `alu_op`=01, `pc_write`=1, `pc_src`=01 in EXEC. Repeat with `zero`=0 → `pc_write`=0. BNE (1100) shows the inverse.
- JMP (1101) → `pc_write`=1, `pc_src`=10 in EXEC, `reg_write` never 1. 3 cycles.
- Opcode 1110 → with `CTRL_ILLEGAL_TRAP_EN`: `illegal`=1 and stuck until reset. Without it: NOP, next FETCH after 3 cycles.
- `reset_n` low during MEM of ST → `mem_write` drops asynchronously; after release, state is FETCH and `op_code`=0000.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC control path: opcodes, ALU class and PC source encodings, FSM states.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package risc_pkg;

  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;
  localparam logic [3:0] OP_RMIN = 4'b0010;
  localparam logic [3:0] OP_RMAX = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1101;

  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_RMIN) && (op <= OP_RMAX);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_mem(op) || is_rtype(op) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state/opcode to datapath strobe decoder for control_fsm.
// All outputs are forced low while en (the active-low reset, released) is 0.
module ctrl_out_decode
  import risc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           en,
  input  state_t         state,
  input  logic [OPW-1:0] op_code,
  input  logic           mem_ready,
  input  logic           zero,
  output logic [1:0]     alu_op,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           mem_read,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           alu_src,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write
);

  logic [3:0] op;
  logic       br_taken;

  assign op       = 4'(op_code);
  assign br_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  always_comb begin
    alu_op     = ALUOP_FUNC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_INC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    if (en) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          if (is_mem(op)) begin
            alu_op  = ALUOP_ADD;
            alu_src = 1'b1;
          end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
            alu_op   = ALUOP_SUB;
            pc_write = br_taken;
            pc_src   = br_taken ? PCSRC_BR : PCSRC_INC;
          end else if (op == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JMP;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (op == OP_LD);
          mem_write = (op == OP_ST);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op == OP_LD);
          reg_dst    = (op != OP_LD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with latched opcode.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOPs.
module control_fsm
  import risc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] instr_op,
  input  logic           mem_ready,
  input  logic           zero,
  output logic [1:0]     alu_op,
  output logic [OPW-1:0] op_code,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           mem_read,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           alu_src,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal
);

  state_t     state;
  logic [3:0] op;

  assign op = 4'(op_code);

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      op_code <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            op_code <= instr_op;
            state   <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (is_mem(op))
            state <= S_MEM;
          else if (is_rtype(op))
            state <= S_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (!is_legal(op)) begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
`endif
          else
            state <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready)
            state <= (op == OP_LD) ? S_WB : S_FETCH;
        end
        S_WB: state <= S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Gating by reset_n keeps every strobe low for the whole reset, not just after the first edge.
  ctrl_out_decode #(.OPW(OPW)) u_decode (
    .en         (reset_n),
    .state      (state),
    .op_code    (op_code),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .alu_op     (alu_op),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write)
  );

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus pushes one expected output vector per cycle,
// a negedge monitor pops and compares. Honours CTRL_ILLEGAL_TRAP_EN.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] instr_op = '0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;

  logic [1:0] alu_op;
  logic [3:0] op_code;
  logic       ir_write, pc_write, mem_read, mem_write, i_or_d;
  logic [1:0] pc_src;
  logic       alu_src, reg_dst, mem_to_reg, reg_write, illegal;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];
  logic [3:0]  cur_op = '0;
  logic        exp_ill = 1'b0;
  logic [19:0] got;

  always #5 clk = ~clk;

  control_fsm #(.OPW(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_op   (instr_op),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .alu_op     (alu_op),
    .op_code    (op_code),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  assign got = {alu_op, op_code, ir_write, pc_write, pc_src, mem_read, mem_write,
                i_or_d, alu_src, reg_dst, mem_to_reg, reg_write, illegal, 2'b00};

  function automatic logic [19:0] mk(input logic [1:0] aop, input logic irw, input logic pcw,
                                     input logic [1:0] psrc, input logic mr, input logic mw,
                                     input logic iod, input logic asrc, input logic rdst,
                                     input logic m2r, input logic rw);
    return {aop, cur_op, irw, pcw, psrc, mr, mw, iod, asrc, rdst, m2r, rw, exp_ill, 2'b00};
  endfunction

  task automatic step(input logic [3:0] iop, input logic rdy, input logic z,
                      input logic [19:0] e, input string nm);
    instr_op  = iop;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++)
      step(op, 1'b0, 1'b0, mk(2'b00, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0), "fetch_wait");
    step(op, 1'b1, 1'b0, mk(2'b00, 1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0), "fetch_load");
    cur_op = op;
    step(4'hf, 1'b1, 1'b0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "decode");
  endtask

  task automatic do_reset(input int unsigned n, input string nm);
    reset_n = 1'b0;
    cur_op  = '0;
    exp_ill = 1'b0;
    for (int unsigned i = 0; i < n; i++)
      step(4'h0, 1'b1, 1'b0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), nm);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    logic [19:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s op=%h actual=%h required=%h", nm, cur_op, got, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] nops[3];
    nops[0] = 4'b1010; nops[1] = 4'b1110; nops[2] = 4'b1111;
    @(posedge clk);
    #1;
    do_reset(2, "reset_init");

    // R-type 0010: FETCH, DECODE, EXEC, WB, then FETCH again on cycle 5
    fetch(4'b0010, 0);
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "r_exec");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1), "r_wb");

    // LD with two MEM wait cycles
    fetch(4'b0000, 0);
    step(4'h0, 1, 0, mk(2'b10, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0), "ld_exec");
    step(4'h0, 0, 0, mk(2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0), "ld_mem_wait");
    step(4'h0, 0, 0, mk(2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0), "ld_mem_wait");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0), "ld_mem_done");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1), "ld_wb");

    // ST with two FETCH wait cycles
    fetch(4'b0001, 2);
    step(4'h0, 1, 0, mk(2'b10, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0), "st_exec");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0), "st_mem");

    fetch(4'b1011, 0);
    step(4'h0, 1, 1, mk(2'b01, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0), "beq_taken");
    fetch(4'b1011, 0);
    step(4'h0, 1, 0, mk(2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "beq_not_taken");
    fetch(4'b1100, 0);
    step(4'h0, 1, 0, mk(2'b01, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0), "bne_taken");
    fetch(4'b1100, 0);
    step(4'h0, 1, 1, mk(2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "bne_not_taken");

    fetch(4'b1101, 0);
    step(4'h0, 1, 0, mk(2'b00, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0), "jmp_exec");

    // upper edge of the R-type range
    fetch(4'b1001, 0);
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "r9_exec");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1), "r9_wb");

`ifdef CTRL_ILLEGAL_TRAP_EN
    fetch(4'b1110, 0);
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "trap_exec");
    exp_ill = 1'b1;
    for (int unsigned i = 0; i < 3; i++)
      step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "trap_hold");
    do_reset(1, "trap_reset");
`else
    for (int unsigned i = 0; i < 3; i++) begin
      fetch(nops[i], 0);
      step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "nop_exec");
    end
`endif

    // ST aborted by reset while waiting in MEM
    fetch(4'b0001, 0);
    step(4'h0, 1, 0, mk(2'b10, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0), "st2_exec");
    step(4'h0, 0, 0, mk(2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0), "st2_mem_wait");
    do_reset(2, "st_abort");

    fetch(4'b0011, 0);
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0), "r3_exec");
    step(4'h0, 1, 0, mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1), "r3_wb");
    step(4'h0, 0, 0, mk(2'b00, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0), "final_fetch");

    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++)
      @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
